// File: rtl/sort_pkg.sv
// Shared definitions for the sorter and its result collector: state encodings,
// default sizes and the (data, index) frame word.
package sort_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDrain   = 2'd2
  } sort_state_e;

  localparam int unsigned DefLength = 32;
  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefNum    = 1024;

  typedef struct packed {
    logic [DefLength-1:0] data;
    logic [DefWidth-1:0]  index;
  } frame_word_t;

endpackage

// File: rtl/sort_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Storage and read register are not reset.
module sort_frame_ram #(
  parameter int unsigned Depth = 4,
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    // Read register only advances on re_i, so a stalled output stays stable.
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sort_result_collector.sv
// Buffers one sorted frame, checks ordering and index permutation on the fly,
// then replays the frame over a valid/ready handshake.
module sort_result_collector
  import sort_pkg::*;
#(
  parameter int unsigned length = DefLength,
  parameter int unsigned width  = DefWidth,
  parameter int unsigned num    = DefNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [length-1:0] in_data,
  input  logic [width-1:0]  in_index,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [length-1:0] out_data,
  output logic [width-1:0]  out_index,
  output logic              busy,
  output logic              done,
  output logic [width-1:0]  count,
  output logic              order_error,
  output logic              perm_error,
  output logic              overrun_error
);

  localparam int unsigned AW = $clog2(num);
  localparam int unsigned DW = length + width;
  localparam logic [width-1:0] NumW   = width'(num);
  localparam logic [width-1:0] NumM1W = width'(num - 1);

  sort_state_e       state_q, state_d;
  logic [width-1:0]  count_q, count_d;
  logic [width-1:0]  rd_ptr_q, rd_ptr_d;
  logic [num-1:0]    seen_q, seen_d;
  logic [length-1:0] prev_data_q, prev_data_d;
  logic              order_q, order_d;
  logic              perm_q, perm_d;
  logic              ovr_q, ovr_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;

  logic              ram_we, ram_re;
  logic [AW-1:0]     seen_idx;
  logic [DW-1:0]     ram_rdata;

  assign seen_idx = AW'(in_index - width'(1));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    seen_d      = seen_q;
    prev_data_d = prev_data_q;
    order_d     = order_q;
    perm_d      = perm_q;
    ovr_d       = ovr_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StCollect;
          count_d  = '0;
          rd_ptr_d = '0;
          seen_d   = '0;
          order_d  = 1'b0;
          perm_d   = 1'b0;
          ovr_d    = 1'b0;
        end
      end
      StCollect: begin
        if (in_valid) begin
          ram_we      = 1'b1;
          count_d     = count_q + width'(1);
          prev_data_d = in_data;
          if (count_q != '0 && in_data > prev_data_q) begin
            order_d = 1'b1;
          end
          if (in_index == '0 || in_index > NumW || seen_q[seen_idx]) begin
            perm_d = 1'b1;
          end else begin
            seen_d[seen_idx] = 1'b1;
          end
          if (count_q == NumM1W) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (in_valid) begin
          ovr_d = 1'b1;
        end
        // rd_ptr counts reads issued; zero marks the first drain cycle.
        if (done_q) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end else if (rd_ptr_q == '0) begin
          ram_re      = 1'b1;
          rd_ptr_d    = width'(1);
          out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
          if (rd_ptr_q == NumW) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            ram_re   = 1'b1;
            rd_ptr_d = rd_ptr_q + width'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      seen_q      <= '0;
      prev_data_q <= '0;
      order_q     <= 1'b0;
      perm_q      <= 1'b0;
      ovr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      seen_q      <= seen_d;
      prev_data_q <= prev_data_d;
      order_q     <= order_d;
      perm_q      <= perm_d;
      ovr_q       <= ovr_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  sort_frame_ram #(
    .Depth(num),
    .DataW(DW),
    .AddrW(AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(AW'(count_q)),
    .wdata_i({in_data, in_index}),
    .re_i   (ram_re),
    .raddr_i(AW'(rd_ptr_q)),
    .rdata_o(ram_rdata)
  );

  // Unreset RAM output is masked so the data outputs read 0 whenever not valid.
  assign out_data      = out_valid_q ? ram_rdata[DW-1:width] : '0;
  assign out_index     = out_valid_q ? ram_rdata[width-1:0] : '0;
  assign out_valid     = out_valid_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign count         = count_q;
  assign order_error   = order_q;
  assign perm_error    = perm_q;
  assign overrun_error = ovr_q;

endmodule

// File: doc/sort_result_collector.md
Name: sort_result_collector

Overview:
- Downstream consumer of the sorter's write phase. Accepts the stream of sorted (data, original-index) pairs and buffers one full frame of `num` entries.
- Checks on the fly that the stream is non-increasing and that the indices form a permutation of 1..num.
- Replays the frame to a downstream sink over a valid/ready handshake, with per-frame error flags.

Parameters:
- length, 32, data word width in bits (matches the sorter's data width).
- width, 16, index width in bits.
- num, 1024, entries per frame; must satisfy num >= 2 and num <= 2**width - 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle pulse; arms collection of one frame.
- in_valid  in  1  in_data/in_index hold a sorted word this cycle.
- in_data  in  length  sorted data word.
- in_index  in  width  original 1-based position of in_data.
- out_ready  in  1  sink accepts out_data/out_index.
- out_valid  out  1  out_data/out_index valid.
- out_data  out  length  replayed data word.
- out_index  out  width  replayed index.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last word drains.
- count  out  width  number of words captured in the current frame.
- order_error  out  1  sticky: a word was larger than its predecessor.
- perm_error  out  1  sticky: an index was 0, greater than num, or duplicated.
- overrun_error  out  1  sticky: in_valid was seen while in DRAIN.

Behaviour:
- Reset: all outputs 0; state IDLE; write/read pointers 0; seen-bitmap (num bits) cleared. Buffer contents are don't-care.
- States: IDLE, COLLECT, DRAIN. All comparisons are unsigned.
- IDLE:
  - start=1 -> COLLECT next cycle.
  - On that transition, clear count, pointers, bitmap, order_error, perm_error and overrun_error.
  - in_valid in IDLE is ignored, including in the same cycle as start.
- COLLECT, on each in_valid=1:
  - Write {in_data, in_index} at wr_ptr; increment wr_ptr and count.
  - Order check: if count>0 and in_data > prev_data, set order_error. Equal values are legal. prev_data is updated every accepted word.
  - Permutation check: if in_index==0, or in_index>num, or bitmap[in_index-1]==1, set perm_error; otherwise set bitmap[in_index-1].
  - When the num-th word is accepted (count becomes num) -> DRAIN next cycle.
- COLLECT rules:
  - No in_valid -> hold state; there is no timeout.
  - start while busy is ignored.
- DRAIN:
  - Buffer read is registered. out_valid first rises on the 2nd cycle in DRAIN, with out_data/out_index = entry 0.
  - A transfer occurs when out_valid and out_ready are both 1.
  - Back-to-back transfers at one word per cycle are required while out_ready stays high.
  - While out_valid=1 and out_ready=0, out_data/out_index stay stable.
  - out_valid never drops before the last transfer.
  - After the transfer of entry num-1: out_valid=0, done=1 for one cycle, then IDLE.
  - Error flags and count hold until the next start.
- DRAIN, in_valid=1: set overrun_error; the word is discarded.
- Reset mid-operation: immediate abort; frame lost; all outputs return to reset values.
- Pointer wrap: pointers span 0..num-1 and never wrap within a frame.

Decomposition:
- Shared package sort_pkg holds:
  - state encodings (IDLE, COLLECT, DRAIN), shared with the sorter's state constants;
  - default length/width/num constants;
  - a frame-word struct {data, index}.
- One sub-module: sort_frame_ram.
  - Simple dual-port, num x (length+width).
  - One write port, one registered read port; no reset on storage.
- Handshake, checks, bitmap and FSM stay in the top module.

Test Plan:
1. num=4; start; feed (40,3),(30,1),(30,4),(10,2) on consecutive cycles; out_ready=1.
   -> Outputs the same 4 pairs in order on back-to-back cycles; done pulses once; order_error=0; perm_error=0; count=4.
2. num=4; feed (10,1),(20,2),(5,3),(1,4).
   -> order_error=1 after the 2nd word; frame still drains all 4 words unchanged.
3. num=4; feed indices 1,2,2,0.
   -> perm_error=1 at the 3rd word and remains 1; the next start clears it.
4. DRAIN with out_ready toggling 1,0,0,1,1,0,1.
   -> Exactly 4 transfers; out_data constant during every stall; done one cycle after the 4th transfer.
5. in_valid pulse in IDLE coincident with start, then 4 valid words.
   -> First pulse not captured; count=4 from the following words.
   -> in_valid during DRAIN sets overrun_error=1 without changing the output sequence.
6. Assert rst after 2 words in COLLECT.
   -> All outputs 0 and busy=0 while reset is held.
   -> After release, a fresh start and 4 words behave exactly as in scenario 1.
